// File: rtl/hazard_scoreboard_unit_if.sv
// Pipeline <-> hazard unit signal bundle.
// The master side is the pipeline, which drives the register addresses and control bits.
// The slave side is the hazard unit, which returns the stall, flush, forward and MDU strobe signals.
interface hazard_scoreboard_unit_if #(
   parameter int unsigned AW = 5
);
   logic [AW-1:0] a1D, a2D, a3D;
   logic          RegWriteD, MduOpD;
   logic [AW-1:0] a1E, a2E, a3E;
   logic          RegWriteE;
   logic [1:0]    ResultSrcE;
   logic          MduStartE, PCSrcE;
   logic [AW-1:0] a3M, a3W;
   logic          RegWriteM, RegWriteW;
   logic          StallF, StallD, FlushD, FlushE;
   logic [1:0]    Fwd1E, Fwd2E;
   logic          MduWbW, MduBusy;
   logic [AW-1:0] MduRdW;

   modport master (
      output a1D, a2D, a3D, RegWriteD, MduOpD,
      output a1E, a2E, a3E, RegWriteE, ResultSrcE, MduStartE, PCSrcE,
      output a3M, RegWriteM, a3W, RegWriteW,
      input  StallF, StallD, FlushD, FlushE, Fwd1E, Fwd2E, MduWbW, MduRdW, MduBusy
   );

   modport slave (
      input  a1D, a2D, a3D, RegWriteD, MduOpD,
      input  a1E, a2E, a3E, RegWriteE, ResultSrcE, MduStartE, PCSrcE,
      input  a3M, RegWriteM, a3W, RegWriteW,
      output StallF, StallD, FlushD, FlushE, Fwd1E, Fwd2E, MduWbW, MduRdW, MduBusy
   );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for a 5-stage RV32 pipeline.
// Provides M/W operand forwarding, the load-use stall and the branch flush.
// Also scoreboards a single outstanding fixed-latency MUL/DIV op.
module hazard_scoreboard_unit #(
   parameter int unsigned NREG    = 32,
   parameter int unsigned AW      = $clog2(NREG),
   parameter int unsigned MDU_LAT = 4,
   parameter int unsigned FWD_EN  = 1
) (
   input logic clk,
   input logic rst,
   hazard_scoreboard_unit_if.slave hz
);

   logic          busy_q, busy_d;
   logic [AW-1:0] busy_rd_q, busy_rd_d;
   logic [3:0]    cnt_q, cnt_d;

   logic stall_lw, stall_mdu0, stall_mdu1, stall_struc, stall_ilk, stall;

   // True when src names dst and dst is a real register (x0 never creates a dependency).
   function automatic logic hit(input logic [AW-1:0] src, input logic [AW-1:0] dst);
      return (dst != '0) && (src == dst);
   endfunction

   // M beats W; a zero source never forwards.
   function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src,
                                          input logic [AW-1:0] a3m, input logic rwm,
                                          input logic [AW-1:0] a3w, input logic rww);
      if (rwm && hit(src, a3m)) return 2'b10;
      if (rww && hit(src, a3w)) return 2'b01;
      return 2'b00;
   endfunction

   // Scoreboard registers; reset discards any pending MDU op.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q    <= 1'b0;
         busy_rd_q <= '0;
         cnt_q     <= '0;
      end else begin
         busy_q    <= busy_d;
         busy_rd_q <= busy_rd_d;
         cnt_q     <= cnt_d;
      end
   end

   // Scoreboard next state: count down while busy, retire at zero; a new issue overwrites.
   always_comb begin
      busy_d    = busy_q;
      busy_rd_d = busy_rd_q;
      cnt_d     = cnt_q;
      if (busy_q) begin
         if (cnt_q == '0) busy_d = 1'b0;
         else             cnt_d  = cnt_q - 4'd1;
      end
      if (hz.MduStartE) begin
         busy_d    = 1'b1;
         busy_rd_d = hz.a3E;
         cnt_d     = 4'(MDU_LAT - 1);
      end
   end

   // Individual D-stage stall causes.
   always_comb begin
      stall_lw    = (hz.ResultSrcE == 2'b01) && hz.RegWriteE &&
                    (hit(hz.a1D, hz.a3E) || hit(hz.a2D, hz.a3E));
      stall_mdu0  = hz.MduStartE &&
                    (hit(hz.a1D, hz.a3E) || hit(hz.a2D, hz.a3E) ||
                     (hz.RegWriteD && hit(hz.a3D, hz.a3E)));
      stall_mdu1  = busy_q &&
                    (hit(hz.a1D, busy_rd_q) || hit(hz.a2D, busy_rd_q) ||
                     (hz.RegWriteD && hit(hz.a3D, busy_rd_q)));
      stall_struc = hz.MduOpD && (busy_q || hz.MduStartE);
      stall_ilk   = 1'b0;
      if (FWD_EN == 0) begin
         stall_ilk = (hz.RegWriteE && (hit(hz.a1D, hz.a3E) || hit(hz.a2D, hz.a3E))) ||
                     (hz.RegWriteM && (hit(hz.a1D, hz.a3M) || hit(hz.a2D, hz.a3M)));
      end
      stall = stall_lw || stall_mdu0 || stall_mdu1 || stall_struc || stall_ilk;
   end

   // Pipeline control outputs; a taken branch overrides the stall so F can load the target.
   always_comb begin
      hz.StallF  = stall && !hz.PCSrcE;
      hz.StallD  = stall && !hz.PCSrcE;
      hz.FlushD  = hz.PCSrcE;
      hz.FlushE  = stall || hz.PCSrcE;
      hz.Fwd1E   = 2'b00;
      hz.Fwd2E   = 2'b00;
      if (FWD_EN != 0) begin
         hz.Fwd1E = fwd_sel(hz.a1E, hz.a3M, hz.RegWriteM, hz.a3W, hz.RegWriteW);
         hz.Fwd2E = fwd_sel(hz.a2E, hz.a3M, hz.RegWriteM, hz.a3W, hz.RegWriteW);
      end
      hz.MduWbW  = busy_q && (cnt_q == '0);
      hz.MduRdW  = busy_rd_q;
      hz.MduBusy = busy_q;
   end

endmodule
